// File: rtl/recip_pkg.sv
// Shared types and helpers for the reciprocal table generator.
// State encoding plus width-derived constants.
package recip_pkg;

  typedef enum logic [1:0] {
    SAT,
    DIV,
    WR,
    READY
  } state_t;

  localparam int DATA_W_DEF  = 16;
  localparam int DIV_CYC_DEF = DATA_W_DEF + 1;

  function automatic int div_cyc(input int w);
    return w + 1;
  endfunction

  function automatic logic [63:0] recip_sat(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

endpackage

// File: rtl/recip_div_seq.sv
// Sequential restoring divider: 2^DATA_W / divisor,
// one quotient bit per cycle, DATA_W+1 cycles.
module recip_div_seq
  import recip_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W:0]   divisor,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient
);

  localparam int NW      = DATA_W + 1;
  localparam int DIV_CYC = div_cyc(DATA_W);
  localparam int CW      = $clog2(DIV_CYC + 1);

  logic [NW-1:0] rem;
  logic [NW-1:0] q;
  logic [NW-1:0] den;
  logic [CW-1:0] cnt;
  logic [NW:0]   shifted;
  logic [NW:0]   diff;

  assign shifted  = {rem, q[NW-1]};
  assign diff     = shifted - {1'b0, den};
  assign done     = busy && (cnt == CW'(DIV_CYC - 1));
  assign quotient = q[DATA_W-1:0];

  // q doubles as the numerator shift register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      q    <= '0;
      den  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= '0;
      q    <= {1'b1, {DATA_W{1'b0}}};
      den  <= divisor;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (diff[NW]) begin
        rem <= shifted[NW-1:0];
        q   <= {q[NW-2:0], 1'b0};
      end else begin
        rem <= diff[NW-1:0];
        q   <= {q[NW-2:0], 1'b1};
      end
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/recip_lut_gen.sv
// Reciprocal table: fills itself by sequential division
// after reset, then serves registered 1-cycle lookups.
module recip_lut_gen
  import recip_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16,
  parameter int ADR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              reinit,
  output logic              init_done,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADR_W-1:0]  req_adr,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err
);

  localparam int NW = DATA_W + 1;
  localparam logic [DATA_W-1:0] SAT_VAL =
    DATA_W'(recip_sat(DATA_W));

  state_t            state;
  state_t            state_n;
  logic [ADR_W-1:0]  k;
  logic [ADR_W-1:0]  k_n;
  logic [DATA_W-1:0] tbl [DEPTH];
  logic              start;
  logic              busy;
  logic              done;
  logic              wr_en;
  logic [ADR_W-1:0]  wr_adr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] quot;
  logic [NW-1:0]     divisor;
  logic              last;
  logic              accept;
  logic              oor;

  assign last      = (k == ADR_W'(DEPTH - 1));
  // divisor follows the k about to be computed
  assign divisor   = NW'(k_n) + NW'(1);
  assign req_ready = init_done;
  assign accept    = req_valid && init_done;
  assign oor       = {1'b0, req_adr} >= (ADR_W + 1)'(DEPTH);

  recip_div_seq #(
    .DATA_W(DATA_W)
  ) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .quotient(quot)
  );

  always_comb begin
    state_n = state;
    k_n     = k;
    start   = 1'b0;
    wr_en   = 1'b0;
    wr_adr  = k;
    wr_data = quot;
    unique case (state)
      SAT: begin
        wr_en   = 1'b1;
        wr_adr  = '0;
        wr_data = SAT_VAL;
        k_n     = ADR_W'(1);
        start   = 1'b1;
        state_n = DIV;
      end
      DIV: begin
        if (done || !busy) state_n = WR;
      end
      WR: begin
        wr_en = 1'b1;
        if (last) begin
          state_n = READY;
        end else begin
          k_n     = k + ADR_W'(1);
          start   = 1'b1;
          state_n = DIV;
        end
      end
      READY: begin
        if (reinit) state_n = SAT;
      end
      default: state_n = SAT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= SAT;
      k         <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      init_done <= (state_n == READY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else if (wr_en) begin
      tbl[wr_adr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= accept;
      resp_err   <= accept && oor;
      if (accept) resp_data <= oor ? '0 : tbl[req_adr];
    end
  end

endmodule

// File: tb/tb_recip_lut_gen.sv
// Bench for recip_lut_gen: default instance plus DEPTH=10.
// Scoreboard queues carry expected data/err and due cycle.
module tb_recip_lut_gen;

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reinit = 1'b0;
  logic        req_valid = 1'b0;
  logic [3:0]  req_adr = '0;
  logic        init_done;
  logic        req_ready;
  logic        resp_valid;
  logic [15:0] resp_data;
  logic        resp_err;

  logic        reinit1 = 1'b0;
  logic        req_valid1 = 1'b0;
  logic [3:0]  req_adr1 = '0;
  logic        init_done1;
  logic        req_ready1;
  logic        resp_valid1;
  logic [15:0] resp_data1;
  logic        resp_err1;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e0;
  exp_t e1;
  int   n_assert = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  recip_lut_gen dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .reinit    (reinit),
    .init_done (init_done),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_adr   (req_adr),
    .resp_valid(resp_valid),
    .resp_data (resp_data),
    .resp_err  (resp_err)
  );

  recip_lut_gen #(
    .DEPTH(10)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .reinit    (reinit1),
    .init_done (init_done1),
    .req_valid (req_valid1),
    .req_ready (req_ready1),
    .req_adr   (req_adr1),
    .resp_valid(resp_valid1),
    .resp_data (resp_data1),
    .resp_err  (resp_err1)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model(input int k);
    if (k == 0) return 16'hFFFF;
    return 16'(32'd65536 / (k + 1));
  endfunction

  always @(negedge clk) begin
    if (q0.size() > 0 && q0[0].due < cyc) begin
      e0 = q0.pop_front();
      check("dut0_missing_resp", 32'(cyc), 32'(e0.due));
    end
    if (resp_valid === 1'b1) begin
      n_assert++;
      assert (q0.size() > 0) else begin
        n_fail++;
        $error("FAIL dut0_unexpected_resp: observed %h expected none",
               resp_data);
      end
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("dut0_data", 32'(resp_data), 32'(e0.data));
        check("dut0_err", 32'(resp_err), 32'(e0.err));
        check("dut0_latency", 32'(cyc), 32'(e0.due));
      end
    end
  end

  always @(negedge clk) begin
    if (q1.size() > 0 && q1[0].due < cyc) begin
      e1 = q1.pop_front();
      check("dut1_missing_resp", 32'(cyc), 32'(e1.due));
    end
    if (resp_valid1 === 1'b1) begin
      n_assert++;
      assert (q1.size() > 0) else begin
        n_fail++;
        $error("FAIL dut1_unexpected_resp: observed %h expected none",
               resp_data1);
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("dut1_data", 32'(resp_data1), 32'(e1.data));
        check("dut1_err", 32'(resp_err1), 32'(e1.err));
        check("dut1_latency", 32'(cyc), 32'(e1.due));
      end
    end
  end

  task automatic look0(input logic [3:0] a,
                       input logic [15:0] d,
                       input logic e);
    req_valid = 1'b1;
    req_adr   = a;
    q0.push_back('{data: d, err: e, due: cyc + 1});
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic look1(input logic [3:0] a,
                       input logic [15:0] d,
                       input logic e);
    req_valid1 = 1'b1;
    req_adr1   = a;
    q1.push_back('{data: d, err: e, due: cyc + 1});
    @(posedge clk);
    #1;
    req_valid1 = 1'b0;
  endtask

  initial begin
    int n;
    int c0;
    int c1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", 32'(resp_data), 32'd0);
    check("rst_resp_err", 32'(resp_err), 32'd0);
    check("rst_init_done1", 32'(init_done1), 32'd0);

    rst_n = 1'b1;
    n = 0;
    c0 = 0;
    c1 = 0;
    while ((!init_done || !init_done1) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 270) check("ready_before_init", 32'(req_ready), 32'd0);
      if (init_done && c0 == 0) c0 = n;
      if (init_done1 && c1 == 0) c1 = n;
    end
    check("init_cycles", 32'(c0), 32'd271);
    check("init_cycles_depth10", 32'(c1), 32'd163);
    check("ready_eq_done", 32'(req_ready), 32'(init_done));

    look0(4'd0, 16'hFFFF, 1'b0);
    look0(4'd1, 16'h8000, 1'b0);
    look0(4'd2, 16'h5555, 1'b0);
    look0(4'd5, 16'h2AAA, 1'b0);
    look0(4'd6, 16'h2492, 1'b0);
    look0(4'd14, 16'h1111, 1'b0);
    look0(4'd15, 16'h1000, 1'b0);
    @(posedge clk);
    #1;
    check("idle_resp_valid", 32'(resp_valid), 32'd0);
    check("idle_data_hold", 32'(resp_data), 32'h1000);

    for (int i = 0; i < 16; i++) look0(4'(i), model(i), 1'b0);
    repeat (2) @(posedge clk);
    #1;

    look1(4'd9, 16'h1999, 1'b0);
    look1(4'd12, 16'h0000, 1'b1);
    look1(4'd0, 16'hFFFF, 1'b0);
    repeat (2) @(posedge clk);
    #1;

    reinit = 1'b1;
    look0(4'd2, 16'h5555, 1'b0);
    reinit = 1'b0;
    check("reinit_ready_drop", 32'(req_ready), 32'd0);
    req_valid = 1'b1;
    req_adr   = 4'd5;
    n = 0;
    while (!init_done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    check("reinit_cycles", 32'(n), 32'd271);

    reinit = 1'b1;
    @(posedge clk);
    #1;
    reinit = 1'b0;
    repeat (99) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_init_done", 32'(init_done), 32'd0);
    check("abort_resp_valid", 32'(resp_valid), 32'd0);
    check("abort_resp_data", 32'(resp_data), 32'd0);
    check("abort_init_done1", 32'(init_done1), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    while (!init_done && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("restart_cycles", 32'(n), 32'd271);
    look0(4'd3, 16'h4000, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    check("dut0_queue_empty", 32'(q0.size()), 32'd0);
    check("dut1_queue_empty", 32'(q1.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
